// File: rtl/wrap_saed32_dp_tiled.sv
// ---------------------------------------------------------------------------
// wrap_saed32_dp_tiled
//   Dual-port RAM wrapper that tiles 64x8 two-port SRAM macros into a
//   WIDTH x DEPTH array. Adds bit-level write masking (through a
//   read-modify-write sequence), same-word conflict arbitration and
//   read-valid flags.
//
//   Build option: WRAP_COLL_FWD_EN
//     defined   : a read that meets a write to the same word returns the
//                 merged new word with QV = 1 at normal latency.
//     undefined : such a read is squashed (QV = 0, Q = 0); the requester
//                 reissues it.
//
//   Ports (x = 0/1 for the two request ports)
//     CLK    in   clock, also the macro clock
//     RST    in   synchronous reset, active-high
//     CEx    in   request
//     WEx    in   1 = write, 0 = read
//     Ax     in   word address; upper bits select the bank, [5:0] the row
//     Dx     in   write data
//     WEMx   in   bit write mask, 1 = bit written
//     RDYx   out  port accepts a request this cycle
//     Qx     out  read data, zero while QVx = 0
//     QVx    out  read data valid, one cycle after an accepted read
//     COLL   out  one-cycle pulse in the cycle after a same-word conflict
//                 was resolved (aligned with the QV of a colliding read)
//
//   Macro model: wrap_saed32_sram2rw64x8_bhv carries the pin interface of
//   the SRAM2RW64X8 hard macro (CSB/WEB/OEB active-low). The read
//   register samples the array before a same-edge write.
// ---------------------------------------------------------------------------

module wrap_saed32_sram2rw64x8_bhv (
  input  logic       CE1,
  input  logic       CE2,
  input  logic       WEB1,
  input  logic       WEB2,
  input  logic       OEB1,
  input  logic       OEB2,
  input  logic       CSB1,
  input  logic       CSB2,
  input  logic [5:0] A1,
  input  logic [5:0] A2,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  output logic [7:0] O1,
  output logic [7:0] O2
);

  logic [7:0] mem_r [64];
  logic [7:0] o1_r;
  logic [7:0] o2_r;

  // Array update from both ports; both clock pins share one clock, and the
  // wrapper never writes one row from both ports in the same cycle.
  always_ff @(posedge CE1) begin
    if (!CSB1 && !WEB1) begin
      mem_r[A1] <= I1;
    end
    if (!CSB2 && !WEB2) begin
      mem_r[A2] <= I2;
    end
  end

  // Port 1 read register.
  always_ff @(posedge CE1) begin
    if (!CSB1 && WEB1) begin
      o1_r <= mem_r[A1];
    end
  end

  // Port 2 read register.
  always_ff @(posedge CE2) begin
    if (!CSB2 && WEB2) begin
      o2_r <= mem_r[A2];
    end
  end

  assign O1 = OEB1 ? 8'h00 : o1_r;
  assign O2 = OEB2 ? 8'h00 : o2_r;

endmodule

module wrap_saed32_dp_tiled #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 256,
  localparam int NBW   = WIDTH / 8,
  localparam int NBD   = DEPTH / 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE0,
  input  logic             CE1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [AW-1:0]    A0,
  input  logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] WEM0,
  input  logic [WIDTH-1:0] WEM1,
  output logic             RDY0,
  output logic             RDY1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             QV0,
  output logic             QV1,
  output logic             COLL
);

  // RMW_WR is kept as a named encoding only: the merged write commits on
  // the edge that leaves RMW_RD, so any other state recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  function automatic logic [NBW-1:0] lanes_full(input logic [WIDTH-1:0] m);
    logic [NBW-1:0] r;
    for (int l = 0; l < NBW; l++) begin
      r[l] = &m[l*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [NBW-1:0] lanes_any(input logic [WIDTH-1:0] m);
    logic [NBW-1:0] r;
    for (int l = 0; l < NBW; l++) begin
      r[l] = |m[l*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  // Request inputs gathered per port
  logic [1:0]                     ce_s;
  logic [1:0]                     we_s;
  logic [1:0][AW-1:0]             a_s;
  logic [1:0][WIDTH-1:0]          d_s;
  logic [1:0][WIDTH-1:0]          wem_s;

  // Port state
  state_t                         state_r    [2];
  state_t                         state_nx_s [2];
  logic [1:0]                     rdy_r;
  logic [1:0]                     qv_r;
  logic [1:0]                     rd_due_r;
  logic                           coll_r;
  logic [1:0][AW-1:0]             bank_r;
  logic [1:0][AW-1:0]             rmw_a_r;
  logic [1:0][WIDTH-1:0]          rmw_d_r;
  logic [1:0][WIDTH-1:0]          rmw_wem_r;

  // Decoded operation of each port in the current cycle
  logic [1:0]                     accept_s;
  logic [1:0]                     partial_s;
  logic [1:0]                     rmw_s;
  logic [1:0]                     op_vld_s;
  logic [1:0]                     op_wr_s;
  logic [1:0][AW-1:0]             op_a_s;
  logic [1:0][AW-1:0]             bank_s;
  logic [1:0][WIDTH-1:0]          op_d_s;
  logic [1:0][WIDTH-1:0]          op_wem_s;
  logic [1:0][NBW-1:0]            full_s;
  logic [1:0][NBW-1:0]            any_s;

  // Conflict resolution
  logic                           same_s;
  logic                           coll_s;
  logic [1:0]                     rdcoll_s;
  logic [1:0]                     drop_s;

  // Macro drive and return
  logic [1:0][NBW-1:0]            mac_lanes_s;
  logic [1:0]                     mac_wr_s;
  logic [1:0][WIDTH-1:0]          mac_din_s;
  logic [1:0][NBD-1:0][WIDTH-1:0] mac_q_s;
  logic [1:0][WIDTH-1:0]          q_raw_s;

  assign ce_s  = {CE1, CE0};
  assign we_s  = {WE1, WE0};
  assign a_s   = {A1, A0};
  assign d_s   = {D1, D0};
  assign wem_s = {WEM1, WEM0};

  // Per-port request decode; during RMW_RD the latched write is the operation.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      accept_s[p]  = ce_s[p] & rdy_r[p];
      full_s[p]    = lanes_full(wem_s[p]);
      any_s[p]     = lanes_any(wem_s[p]);
      partial_s[p] = |(any_s[p] & ~full_s[p]);
      rmw_s[p]     = (state_r[p] == RMW_RD);
      op_vld_s[p]  = accept_s[p] | rmw_s[p];
      op_wr_s[p]   = rmw_s[p] | we_s[p];
      op_a_s[p]    = rmw_s[p] ? rmw_a_r[p] : a_s[p];
      op_d_s[p]    = rmw_s[p] ? rmw_d_r[p] : d_s[p];
      op_wem_s[p]  = rmw_s[p] ? rmw_wem_r[p] : wem_s[p];
      bank_s[p]    = op_a_s[p] >> 3'd6;
    end
  end

  // An RMW read phase counts as a write for conflicts: the word is owned.
  assign same_s   = op_vld_s[0] & op_vld_s[1] & (op_a_s[0] == op_a_s[1]);
  assign coll_s   = same_s & (op_wr_s[0] | op_wr_s[1]);
  assign drop_s   = {same_s & op_wr_s[0] & op_wr_s[1], 1'b0};
  assign rdcoll_s = {coll_s & ~op_wr_s[1], coll_s & ~op_wr_s[0]};

  // FSM next state and macro lane enables / write data per port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_nx_s[p]  = state_r[p];
      mac_lanes_s[p] = '0;
      mac_wr_s[p]    = 1'b0;
      mac_din_s[p]   = op_d_s[p];
      case (state_r[p])
        IDLE: begin
          if (accept_s[p] && !we_s[p]) begin
            mac_lanes_s[p] = {NBW{1'b1}};
          end else if (accept_s[p] && !drop_s[p]) begin
            if (partial_s[p]) begin
              // first RMW phase: read the whole word, merge next cycle
              mac_lanes_s[p] = {NBW{1'b1}};
              state_nx_s[p]  = RMW_RD;
            end else begin
              mac_lanes_s[p] = full_s[p];
              mac_wr_s[p]    = 1'b1;
            end
          end else begin
            mac_lanes_s[p] = '0;
          end
        end
        RMW_RD: begin
          state_nx_s[p] = IDLE;
          if (!drop_s[p]) begin
            mac_lanes_s[p] = lanes_any(rmw_wem_r[p]);
            mac_wr_s[p]    = 1'b1;
            mac_din_s[p]   = merge(q_raw_s[p], rmw_d_r[p], rmw_wem_r[p]);
          end else begin
            mac_lanes_s[p] = '0;
          end
        end
        default: begin
          state_nx_s[p] = IDLE;
        end
      endcase
      // reset cancels any macro access in the same edge, incl. a pending RMW write
      mac_lanes_s[p] = mac_lanes_s[p] & {NBW{~RST}};
    end
  end

  // Bank select of macro read data by the bank registered with the read.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_raw_s[p] = '0;
      for (int b = 0; b < NBD; b++) begin
        q_raw_s[p] = q_raw_s[p] | (mac_q_s[p][b] & {WIDTH{bank_r[p] == AW'(b)}});
      end
    end
  end

  // Port state, valid flags and RMW capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int p = 0; p < 2; p++) begin
        state_r[p] <= IDLE;
      end
      rdy_r     <= 2'b11;
      qv_r      <= 2'b00;
      rd_due_r  <= 2'b00;
      coll_r    <= 1'b0;
      bank_r    <= '0;
      rmw_a_r   <= '0;
      rmw_d_r   <= '0;
      rmw_wem_r <= '0;
    end else begin
      coll_r <= coll_s;
      for (int p = 0; p < 2; p++) begin
        state_r[p]  <= state_nx_s[p];
        rdy_r[p]    <= (state_nx_s[p] == IDLE);
        rd_due_r[p] <= (|mac_lanes_s[p]) & ~mac_wr_s[p];
        bank_r[p]   <= bank_s[p];
`ifdef WRAP_COLL_FWD_EN
        qv_r[p]     <= accept_s[p] & ~we_s[p];
`else
        qv_r[p]     <= accept_s[p] & ~we_s[p] & ~rdcoll_s[p];
`endif
        if (accept_s[p] && we_s[p] && partial_s[p] && !drop_s[p]) begin
          rmw_a_r[p]   <= op_a_s[p];
          rmw_d_r[p]   <= op_d_s[p];
          rmw_wem_r[p] <= op_wem_s[p];
        end
      end
    end
  end

`ifdef WRAP_COLL_FWD_EN
  logic [1:0]            fwd_r;
  logic [1:0][WIDTH-1:0] fwd_d_r;
  logic [1:0][WIDTH-1:0] fwd_wem_r;

  // Capture the other port's write for merging into a colliding read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_r     <= 2'b00;
      fwd_d_r   <= '0;
      fwd_wem_r <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        fwd_r[p]     <= rdcoll_s[p];
        fwd_d_r[p]   <= op_d_s[1-p];
        fwd_wem_r[p] <= op_wem_s[1-p];
      end
    end
  end

  assign Q0 = qv_r[0] ? (fwd_r[0] ? merge(q_raw_s[0], fwd_d_r[0], fwd_wem_r[0]) : q_raw_s[0])
                      : {WIDTH{1'b0}};
  assign Q1 = qv_r[1] ? (fwd_r[1] ? merge(q_raw_s[1], fwd_d_r[1], fwd_wem_r[1]) : q_raw_s[1])
                      : {WIDTH{1'b0}};
`else
  assign Q0 = qv_r[0] ? q_raw_s[0] : {WIDTH{1'b0}};
  assign Q1 = qv_r[1] ? q_raw_s[1] : {WIDTH{1'b0}};
`endif

  assign RDY0 = rdy_r[0];
  assign RDY1 = rdy_r[1];
  assign QV0  = qv_r[0];
  assign QV1  = qv_r[1];
  assign COLL = coll_r;

  // Macro array: wrapper port 0 uses macro port 1, wrapper port 1 uses port 2.
  for (genvar b = 0; b < NBD; b++) begin : g_bank
    for (genvar l = 0; l < NBW; l++) begin : g_lane
      wrap_saed32_sram2rw64x8_bhv u_mac (
        .CE1  (CLK),
        .CE2  (CLK),
        .WEB1 (~mac_wr_s[0]),
        .WEB2 (~mac_wr_s[1]),
        .OEB1 (~rd_due_r[0]),
        .OEB2 (~rd_due_r[1]),
        .CSB1 (~(mac_lanes_s[0][l] & (bank_s[0] == AW'(b)))),
        .CSB2 (~(mac_lanes_s[1][l] & (bank_s[1] == AW'(b)))),
        .A1   (op_a_s[0][5:0]),
        .A2   (op_a_s[1][5:0]),
        .I1   (mac_din_s[0][l*8 +: 8]),
        .I2   (mac_din_s[1][l*8 +: 8]),
        .O1   (mac_q_s[0][b][l*8 +: 8]),
        .O2   (mac_q_s[1][b][l*8 +: 8])
      );
    end
  end

endmodule

// File: tb/tb_wrap_saed32_dp_tiled.sv
// Directed bench for wrap_saed32_dp_tiled (WIDTH=32, DEPTH=256). Expected
// read results are queued when a read is driven and compared when QV is due.
module tb_wrap_saed32_dp_tiled;

  logic        clk;
  logic        rst;
  logic        ce0, ce1, we0, we1;
  logic [7:0]  a0, a1;
  logic [31:0] d0, d1, wem0, wem1;
  logic        rdy0, rdy1, qv0, qv1, coll;
  logic [31:0] q0, q1;

  typedef struct packed {
    logic        qv;
    logic [31:0] q;
  } exp_t;

  exp_t        expq0[$];
  exp_t        expq1[$];
  logic [1:0]  rd_issue;
  logic [31:0] model [256];
  int          checks;
  int          errors;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  wrap_saed32_dp_tiled #(.WIDTH(32), .DEPTH(256)) dut (
    .CLK(clk), .RST(rst),
    .CE0(ce0), .CE1(ce1), .WE0(we0), .WE1(we1),
    .A0(a0), .A1(a1), .D0(d0), .D1(d1), .WEM0(wem0), .WEM1(wem1),
    .RDY0(rdy0), .RDY1(rdy1), .Q0(q0), .Q1(q1), .QV0(qv0), .QV1(qv1),
    .COLL(coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d,
                                      input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int p, input logic [7:0] a, input logic [31:0] d, input logic [31:0] m);
    if (p == 0) begin
      ce0 = 1'b1; we0 = 1'b1; a0 = a; d0 = d; wem0 = m;
    end else begin
      ce1 = 1'b1; we1 = 1'b1; a1 = a; d1 = d; wem1 = m;
    end
  endtask

  task automatic rd(input int p, input logic [7:0] a, input logic qv, input logic [31:0] q);
    exp_t e;
    e.qv = qv;
    e.q  = q;
    if (p == 0) begin
      ce0 = 1'b1; we0 = 1'b0; a0 = a; expq0.push_back(e); rd_issue[0] = 1'b1;
    end else begin
      ce1 = 1'b1; we1 = 1'b0; a1 = a; expq1.push_back(e); rd_issue[1] = 1'b1;
    end
  endtask

  // One clock: check read results and COLL in the cycle after the edge.
  task automatic tick(input logic exp_coll);
    logic [1:0] due;
    exp_t e;
    due = rd_issue;
    rd_issue = 2'b00;
    @(posedge clk);
    #1;
    if (due[0]) begin
      e = expq0.pop_front();
      chk("qv0", {31'd0, qv0}, {31'd0, e.qv});
      chk("q0", q0, e.q);
    end else begin
      chk("qv0_idle", {31'd0, qv0}, 32'd0);
      chk("q0_idle", q0, 32'd0);
    end
    if (due[1]) begin
      e = expq1.pop_front();
      chk("qv1", {31'd0, qv1}, {31'd0, e.qv});
      chk("q1", q1, e.q);
    end else begin
      chk("qv1_idle", {31'd0, qv1}, 32'd0);
      chk("q1_idle", q1, 32'd0);
    end
    chk("coll", {31'd0, coll}, {31'd0, exp_coll});
    ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; rd_issue = 2'b00;
    rst = 1'b1;
    ce0 = 1'b0; ce1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = 8'h00; a1 = 8'h00; d0 = 32'h0; d1 = 32'h0; wem0 = 32'h0; wem1 = 32'h0;

    // reset state
    tick(1'b0);
    tick(1'b0);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
    chk("rst_rdy1", {31'd0, rdy1}, 32'd1);
    rst = 1'b0;

    // full-word write then read
    wr(0, 8'h41, 32'hDEAD_BEEF, ALL1);
    tick(1'b0);
    chk("t1_rdy0", {31'd0, rdy0}, 32'd1);
    model[8'h41] = 32'hDEAD_BEEF;
    rd(0, 8'h41, 1'b1, model[8'h41]);
    tick(1'b0);
    tick(1'b0);

    // partial write through read-modify-write
    wr(0, 8'h10, ALL1, ALL1);
    tick(1'b0);
    model[8'h10] = ALL1;
    wr(0, 8'h10, 32'h0, 32'h0000_F00F);
    tick(1'b0);
    chk("t2_rdy0_busy", {31'd0, rdy0}, 32'd0);
    tick(1'b0);
    chk("t2_rdy0_back", {31'd0, rdy0}, 32'd1);
    model[8'h10] = mrg(model[8'h10], 32'h0, 32'h0000_F00F);
    rd(0, 8'h10, 1'b1, model[8'h10]);
    tick(1'b0);

    // write/write conflict: port 0 wins
    wr(0, 8'h80, 32'h1111_1111, ALL1);
    wr(1, 8'h80, 32'h2222_2222, ALL1);
    tick(1'b1);
    tick(1'b0);
    model[8'h80] = 32'h1111_1111;
    rd(0, 8'h80, 1'b1, model[8'h80]);
    rd(1, 8'h80, 1'b1, model[8'h80]);
    tick(1'b0);

    // port 1 partial write loses to port 0: aborted, stays ready
    wr(0, 8'h90, 32'hAAAA_AAAA, ALL1);
    wr(1, 8'h90, 32'h0000_FFFF, 32'h0000_00FF);
    tick(1'b1);
    chk("t3b_rdy1", {31'd0, rdy1}, 32'd1);
    model[8'h90] = 32'hAAAA_AAAA;
    tick(1'b0);
    rd(1, 8'h90, 1'b1, model[8'h90]);
    tick(1'b0);

    // read/write conflict
    wr(0, 8'h20, 32'h0, ALL1);
    tick(1'b0);
    model[8'h20] = 32'h0;
    wr(0, 8'h20, 32'hA5A5_A5A5, ALL1);
`ifdef WRAP_COLL_FWD_EN
    rd(1, 8'h20, 1'b1, 32'hA5A5_A5A5);
`else
    rd(1, 8'h20, 1'b0, 32'h0);
`endif
    tick(1'b1);
    model[8'h20] = 32'hA5A5_A5A5;
    rd(1, 8'h20, 1'b1, model[8'h20]);
    tick(1'b0);

    // reset during the write phase of a partial write
    wr(0, 8'h30, 32'h1234_5678, ALL1);
    tick(1'b0);
    model[8'h30] = 32'h1234_5678;
    wr(0, 8'h30, 32'h0, 32'h0000_00F0);
    tick(1'b0);
    chk("t5_rdy0_busy", {31'd0, rdy0}, 32'd0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    chk("t5_rdy0_after_rst", {31'd0, rdy0}, 32'd1);
    rd(0, 8'h30, 1'b1, model[8'h30]);
    tick(1'b0);

    // back-to-back reads across the bank boundary
    wr(0, 8'h3F, 32'h0BAD_F00D, ALL1);
    wr(1, 8'h40, 32'hCAFE_BABE, ALL1);
    tick(1'b0);
    model[8'h3F] = 32'h0BAD_F00D;
    model[8'h40] = 32'hCAFE_BABE;
    rd(0, 8'h3F, 1'b1, model[8'h3F]);
    tick(1'b0);
    rd(0, 8'h40, 1'b1, model[8'h40]);
    tick(1'b0);
    tick(1'b0);

    // different words in one bank on both ports
    wr(1, 8'h06, 32'h6666_6666, ALL1);
    tick(1'b0);
    model[8'h06] = 32'h6666_6666;
    wr(0, 8'h05, 32'h55AA_55AA, ALL1);
    rd(1, 8'h06, 1'b1, model[8'h06]);
    tick(1'b0);
    model[8'h05] = 32'h55AA_55AA;
    rd(0, 8'h05, 1'b1, model[8'h05]);
    tick(1'b0);

    // port 1 partial write alongside a port 0 read of another bank
    wr(1, 8'hC3, 32'h1234_5678, ALL1);
    tick(1'b0);
    model[8'hC3] = 32'h1234_5678;
    wr(1, 8'hC3, 32'hABCD_EF01, 32'h0F0F_0000);
    rd(0, 8'h41, 1'b1, model[8'h41]);
    tick(1'b0);
    chk("t8_rdy1_busy", {31'd0, rdy1}, 32'd0);
    tick(1'b0);
    chk("t8_rdy1_back", {31'd0, rdy1}, 32'd1);
    model[8'hC3] = mrg(model[8'hC3], 32'hABCD_EF01, 32'h0F0F_0000);
    rd(1, 8'hC3, 1'b1, model[8'hC3]);
    tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
